serial_adder: RTL and testbench

- Bit-serial N-bit adder. Adds two operands one bit per clock, LSB first.
- Each bit slice is a full adder built from two half-adder cells plus an OR; a carry flip-flop links the slices across cycles.
- Sits directly downstream of the half-adder cell and consumes its sum/carry outputs.
- Serves as the sequential arithmetic stage feeding the lab datapath; start/done handshake toward the controller.

---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder slice per clock, LSB first, with a
// start/busy/done handshake and a registered {cout, sum} result.
module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  psum;
    logic          carry;
    logic [CW-1:0] cnt;

    logic ha1_s;
    logic ha1_c;
    logic ha2_c;
    logic bit_s;
    logic carry_next;
    logic last;

    // One slice: two half adders plus an OR on their carries.
    assign ha1_s      = a_sh[0] ^ b_sh[0];
    assign ha1_c      = a_sh[0] & b_sh[0];
    assign bit_s      = ha1_s ^ carry;
    assign ha2_c      = ha1_s & carry;
    assign carry_next = ha1_c | ha2_c;
    assign last       = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        psum  <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[N-1:1]};
                    b_sh  <= {1'b0, b_sh[N-1:1]};
                    psum  <= {bit_s, psum[N-1:1]};
                    carry <= carry_next;
                    // The final slice bypasses psum so sum lands on the same edge.
                    if (last) begin
                        sum  <= {bit_s, psum[N-1:1]};
                        cout <= carry_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder against an arithmetic model.
module tb_serial_adder;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    int n_vec = 0;
    int n_err = 0;
    logic [N-1:0] prev_sum = '0;

    serial_adder #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    function automatic logic [N:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic ci);
        return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
    endfunction

    task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
        @(negedge clk);
        a = x; b = y; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observe until done (bounded); reports latency, busy cycles and whether sum held.
    task automatic wait_done(input logic [N-1:0] prior, output int lat, output int busy_n,
                             output bit held);
        lat = 0; busy_n = 0; held = 1'b1;
        while (done !== 1'b1 && lat < 4 * N) begin
            if (busy === 1'b1) busy_n++;
            if (sum !== prior) held = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #2;
        n_vec++;
        if ({busy, done, sum, cout} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic run_check(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                             input logic ci, input bit scramble);
        int lat, busy_n;
        bit held;
        logic [N:0] exp;
        exp = ref_add(x, y, ci);
        launch(x, y, ci);
        if (scramble) begin
            a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
        end
        wait_done(prev_sum, lat, busy_n, held);
        n_vec++;
        if (lat !== N) begin
            n_err++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, N);
        end
        n_vec++;
        if (busy_n !== N) begin
            n_err++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_n, N);
        end
        n_vec++;
        if (!held) begin
            n_err++;
            $display("FAIL %s_sum_held: sum changed during RUN, want %h", name, prev_sum);
        end
        n_vec++;
        if ({cout, sum} !== exp) begin
            n_err++;
            $display("FAIL %s_result: got cout=%b sum=%h want cout=%b sum=%h",
                     name, cout, sum, exp[N], exp[N-1:0]);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || {cout, sum} !== exp) begin
            n_err++;
            $display("FAIL %s_after_done: got done=%b sum=%h want done=0 sum=%h",
                     name, done, sum, exp[N-1:0]);
        end
        prev_sum = exp[N-1:0];
    endtask

    task automatic test_directed;
        run_check("zero", 8'h00, 8'h00, 1'b0, 1'b0);
        run_check("ff_plus_1", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_check("3c_42", 8'h3C, 8'h42, 1'b0, 1'b0);
        run_check("ripple", 8'hA5, 8'h5A, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++)
            run_check("random", N'($urandom), N'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic test_ignore_start;
        int lat, busy_n, extra;
        bit held;
        logic [N:0] exp;
        exp = ref_add(8'h12, 8'h34, 1'b0);
        launch(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        a = 8'h11; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(prev_sum, lat, busy_n, held);
        n_vec++;
        if (lat !== N - 2 || {cout, sum} !== exp) begin
            n_err++;
            $display("FAIL ignore_start_result: got lat=%0d sum=%h cout=%b want lat=%0d sum=%h cout=%b",
                     lat, sum, cout, N - 2, exp[N-1:0], exp[N]);
        end
        extra = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL ignore_start_queued: got %0d active cycles after done want 0", extra);
        end
        prev_sum = exp[N-1:0];
    endtask

    task automatic test_mid_reset;
        int activity;
        launch(8'hC3, 8'h3C, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, sum, cout} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        activity = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) activity++;
        end
        n_vec++;
        if (activity !== 0) begin
            n_err++;
            $display("FAIL mid_reset_no_done: got %0d active cycles want 0", activity);
        end
        prev_sum = '0;
        run_check("after_reset", 8'h80, 8'h80, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int pulses, prev_t, bad_gap, bad_res;
        logic [N:0] exp;
        exp = ref_add(8'h01, 8'h02, 1'b0);
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        pulses = 0; prev_t = -1; bad_gap = 0; bad_res = 0;
        for (int t = 0; t < 5 * (N + 2); t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if ({cout, sum} !== exp) bad_res++;
                if (prev_t >= 0 && t - prev_t != N + 2) bad_gap++;
                prev_t = t;
                pulses++;
            end
        end
        start = 1'b0;
        n_vec++;
        if (pulses < 4) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d want at least 4", pulses);
        end
        n_vec++;
        if (bad_gap !== 0) begin
            n_err++;
            $display("FAIL b2b_period: got %0d bad gaps want 0 (period %0d)", bad_gap, N + 2);
        end
        n_vec++;
        if (bad_res !== 0) begin
            n_err++;
            $display("FAIL b2b_result: got %0d wrong results want 0 (sum=%h)", bad_res,
                     exp[N-1:0]);
        end
        for (int i = 0; i < N + 3; i++) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_random();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
